// File: rtl/pe_mac_pkg.sv
// Shared types and helpers for the AMNS processing-element multiply-accumulate unit.
package pe_mac_pkg;

  typedef enum logic [2:0] {
    OP_MUL            = 3'd0,
    OP_MUL_ADD_C      = 3'd1,
    OP_MUL_ACC        = 3'd2,
    OP_MUL_ACC_SHIFT  = 3'd3,
    OP_MUL_CASC       = 3'd4,
    OP_MUL_CASC_SHIFT = 3'd5,
    OP_HOLD           = 3'd6,
    OP_RSVD           = 3'd7
  } op_t;

  localparam int OP_W = 3;

  function automatic int mac_latency(input int abreg, input int mreg);
    return abreg + mreg + 1;
  endfunction

endpackage

// File: rtl/pe_mac_delay.sv
// N-stage register chain with async active-high reset; N = 0 is a plain wire.
module pe_mac_delay #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (STAGES == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_regs
    logic [STAGES-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < STAGES; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign o_q = r_pipe[STAGES-1];
  end

endmodule

// File: rtl/pe_mac_unit.sv
// Pipelined P = A*B + Z multiply-accumulate element; Z chosen per op and carried with the data.
module pe_mac_unit
  import pe_mac_pkg::*;
#(
  parameter int A_WIDTH = 27,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48,
  parameter int ABREG   = 1,
  parameter int MREG    = 1,
  parameter int CREG    = 1,
  parameter int SHIFT   = 17
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  input  logic [P_WIDTH-1:0] c_i,
  input  logic               c_en_i,
  input  logic [P_WIDTH-1:0] pcin_i,
  output logic [P_WIDTH-1:0] p_o,
  output logic               valid_o,
  output logic [P_WIDTH-1:0] pcout_o
);

  localparam int LATENCY = mac_latency(ABREG, MREG);
  localparam int AB_W    = 1 + OP_W + A_WIDTH + B_WIDTH;
  localparam int M_W     = 1 + OP_W + P_WIDTH;

  if (ABREG < 0 || ABREG > 2 || MREG < 0 || MREG > 1 || CREG < 0 || CREG > 1 ||
      SHIFT < 1 || SHIFT >= P_WIDTH || P_WIDTH < A_WIDTH + B_WIDTH || LATENCY > 4)
  begin : g_param_err
    $error("pe_mac_unit: illegal parameter set (ABREG=%0d MREG=%0d CREG=%0d SHIFT=%0d P_WIDTH=%0d)",
           ABREG, MREG, CREG, SHIFT, P_WIDTH);
  end

  logic [AB_W-1:0]    w_ab_d;
  logic [AB_W-1:0]    w_ab_q;
  logic               w_ab_valid;
  logic [OP_W-1:0]    w_ab_op;
  logic [A_WIDTH-1:0] w_a;
  logic [B_WIDTH-1:0] w_b;
  logic [P_WIDTH-1:0] w_prod;

  logic [M_W-1:0]     w_m_d;
  logic [M_W-1:0]     w_m_q;
  logic               w_m_valid;
  logic [OP_W-1:0]    w_m_op;
  logic [P_WIDTH-1:0] w_m;

  logic [P_WIDTH-1:0] w_c;
  logic [P_WIDTH-1:0] w_z;
  logic               w_upd;
  op_t                w_op;

  logic [P_WIDTH-1:0] r_p;
  logic               r_valid;

  assign w_ab_d = {valid_i, op_i, a_i, b_i};

  pe_mac_delay #(.WIDTH(AB_W), .STAGES(ABREG)) u_ab_dly (
    .i_clock (clock_i),
    .i_reset (reset_i),
    .i_d     (w_ab_d),
    .o_q     (w_ab_q)
  );

  assign {w_ab_valid, w_ab_op, w_a, w_b} = w_ab_q;

  // P_WIDTH >= A_WIDTH+B_WIDTH, so the product never wraps.
  assign w_prod = P_WIDTH'(w_a) * P_WIDTH'(w_b);
  assign w_m_d  = {w_ab_valid, w_ab_op, w_prod};

  pe_mac_delay #(.WIDTH(M_W), .STAGES(MREG)) u_m_dly (
    .i_clock (clock_i),
    .i_reset (reset_i),
    .i_d     (w_m_d),
    .o_q     (w_m_q)
  );

  assign {w_m_valid, w_m_op, w_m} = w_m_q;

  if (CREG == 1) begin : g_creg
    logic [P_WIDTH-1:0] r_c;

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        r_c <= '0;
      end else if (c_en_i) begin
        r_c <= c_i;
      end
    end

    assign w_c = r_c;
  end else begin : g_no_creg
    assign w_c = c_i;
  end

  assign w_op = op_t'(w_m_op);

  always_comb begin
    w_z   = '0;
    w_upd = 1'b1;
    case (w_op)
      OP_MUL:            w_z = '0;
      OP_MUL_ADD_C:      w_z = w_c;
      OP_MUL_ACC:        w_z = r_p;
      OP_MUL_ACC_SHIFT:  w_z = r_p >> SHIFT;
      OP_MUL_CASC:       w_z = pcin_i;
      OP_MUL_CASC_SHIFT: w_z = pcin_i >> SHIFT;
      default:           w_upd = 1'b0;
    endcase
  end

  // Accumulate feeds r_p straight back, so back-to-back MUL_ACC needs no stall.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_m_valid;
      if (w_m_valid && w_upd) begin
        r_p <= w_m + w_z;
      end
    end
  end

  assign p_o     = r_p;
  assign pcout_o = r_p;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_pe_mac_unit.sv
// Bench for pe_mac_unit: three configurations share stimulus and are scored against a queue-free history model.
module tb_pe_mac_unit;
  import pe_mac_pkg::*;

  localparam int AW = 27;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam int SH = 17;
  localparam int NI = 3;

  typedef struct {
    logic          v;
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
  } opr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vin = 1'b0;
  logic [2:0]    op  = '0;
  logic [AW-1:0] a   = '0;
  logic [BW-1:0] b   = '0;
  logic [PW-1:0] c   = '0;
  logic          cen = 1'b0;
  logic [PW-1:0] pcin = '0;

  logic [PW-1:0] p_o  [NI];
  logic [PW-1:0] pc_o [NI];
  logic          v_o  [NI];

  opr_t          hist [256];
  int            n_edge = 0;
  int            first_edge = 0;
  logic [PW-1:0] mp [NI];
  logic [PW-1:0] mc [NI];
  logic          mv [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instance 0: defaults (latency 3); 1: latency 1, CREG=0; 2: latency 4
  pe_mac_unit u_def (
    .clock_i(clk), .reset_i(rst), .valid_i(vin), .op_i(op), .a_i(a), .b_i(b),
    .c_i(c), .c_en_i(cen), .pcin_i(pcin), .p_o(p_o[0]), .valid_o(v_o[0]), .pcout_o(pc_o[0]));

  pe_mac_unit #(.ABREG(0), .MREG(0), .CREG(0)) u_l1 (
    .clock_i(clk), .reset_i(rst), .valid_i(vin), .op_i(op), .a_i(a), .b_i(b),
    .c_i(c), .c_en_i(cen), .pcin_i(pcin), .p_o(p_o[1]), .valid_o(v_o[1]), .pcout_o(pc_o[1]));

  pe_mac_unit #(.ABREG(2), .MREG(1), .CREG(1)) u_l4 (
    .clock_i(clk), .reset_i(rst), .valid_i(vin), .op_i(op), .a_i(a), .b_i(b),
    .c_i(c), .c_en_i(cen), .pcin_i(pcin), .p_o(p_o[2]), .valid_o(v_o[2]), .pcout_o(pc_o[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : (k == 1) ? 1 : 4;
  endfunction

  function automatic bit creg_of(input int k);
    return (k != 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mp[k] = '0;
      mc[k] = '0;
      mv[k] = 1'b0;
    end
    first_edge = n_edge;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then score every instance.
  task automatic step(input logic v, input logic [2:0] o, input logic [AW-1:0] ia,
                      input logic [BW-1:0] ib, input logic [PW-1:0] ic, input logic icen,
                      input logic [PW-1:0] ipc);
    opr_t          e;
    logic [PW-1:0] m;
    logic [PW-1:0] z;
    int            idx;
    vin = v; op = o; a = ia; b = ib; c = ic; cen = icen; pcin = ipc;
    @(posedge clk);
    hist[n_edge % 256] = '{vin, op, a, b};
    for (int k = 0; k < NI; k++) begin
      idx = n_edge - (lat_of(k) - 1);
      if (idx >= first_edge) e = hist[idx % 256];
      else e = '{1'b0, 3'd0, '0, '0};
      mv[k] = e.v;
      if (e.v) begin
        m = PW'(e.a) * PW'(e.b);
        z = '0;
        case (e.op)
          3'd1: z = creg_of(k) ? mc[k] : c;
          3'd2: z = mp[k];
          3'd3: z = mp[k] >> SH;
          3'd4: z = pcin;
          3'd5: z = pcin >> SH;
          default: z = '0;
        endcase
        if (e.op < 3'd6) mp[k] = m + z;
      end
      if (creg_of(k) && cen) mc[k] = c;
    end
    n_edge++;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (p_o[k] !== mp[k]) begin
        errors++;
        $display("FAIL model_p inst%0d edge%0d got %h want %h", k, n_edge, p_o[k], mp[k]);
      end
      checks++;
      if (v_o[k] !== mv[k]) begin
        errors++;
        $display("FAIL model_valid inst%0d edge%0d got %b want %b", k, n_edge, v_o[k], mv[k]);
      end
      checks++;
      if (pc_o[k] !== mp[k]) begin
        errors++;
        $display("FAIL model_pcout inst%0d edge%0d got %h want %h", k, n_edge, pc_o[k], mp[k]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (p_o[k] !== '0 || v_o[k] !== 1'b0 || pc_o[k] !== '0) begin
        errors++;
        $display("FAIL reset_state inst%0d got p=%h v=%b pc=%h want 0", k, p_o[k], v_o[k], pc_o[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_mul();
    logic [PW-1:0] gp [1:6];
    logic          gv [1:6];
    logic [PW-1:0] lp [1:6];
    logic          ev [1:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [PW-1:0] big = 48'h1FFF_F7FC_0001; // (2^27-1)*(2^18-1)
    for (int i = 1; i <= 6; i++) begin
      if (i == 1)      step(1'b1, OP_MUL, 27'd5, 18'd7, '0, 1'b0, '0);
      else if (i == 2) step(1'b1, OP_MUL, '1, '1, '0, 1'b0, '0);
      else             step(1'b0, OP_MUL, '0, '0, '0, 1'b0, '0);
      gp[i] = p_o[0]; gv[i] = v_o[0]; lp[i] = p_o[1];
    end
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (gv[i] !== ev[i]) begin
        errors++;
        $display("FAIL mul_valid cycle%0d got %b want %b", i, gv[i], ev[i]);
      end
    end
    checks++;
    if (gp[3] !== 48'd35) begin errors++; $display("FAIL mul_small got %h want %h", gp[3], 48'd35); end
    checks++;
    if (gp[4] !== big) begin errors++; $display("FAIL mul_max got %h want %h", gp[4], big); end
    checks++;
    if (gp[6] !== big) begin errors++; $display("FAIL mul_hold_idle got %h want %h", gp[6], big); end
    checks++;
    if (lp[1] !== 48'd35 || lp[2] !== big) begin
      errors++;
      $display("FAIL mul_lat1 got %h,%h want %h,%h", lp[1], lp[2], 48'd35, big);
    end
  endtask

  task automatic test_mul_acc();
    logic [PW-1:0] gp [1:8];
    logic          gv [1:8];
    logic [PW-1:0] ep [0:4] = '{48'd1, 48'd13, 48'd25, 48'd37, 48'd49};
    for (int i = 1; i <= 8; i++) begin
      if (i == 1)      step(1'b1, OP_MUL, 27'd1, 18'd1, '0, 1'b0, '0);
      else if (i <= 5) step(1'b1, OP_MUL_ACC, 27'd3, 18'd4, '0, 1'b0, '0);
      else             step(1'b0, OP_MUL, '0, '0, '0, 1'b0, '0);
      gp[i] = p_o[0]; gv[i] = v_o[0];
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gp[i+3] !== ep[i] || gv[i+3] !== 1'b1) begin
        errors++;
        $display("FAIL mul_acc step%0d got p=%0d v=%b want p=%0d v=1", i, gp[i+3], gv[i+3], ep[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [PW-1:0] pc = 48'h4_0000;
    logic [PW-1:0] gp [1:5];
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) step(1'b1, OP_MUL_CASC_SHIFT, 27'd1, 18'd1, '0, 1'b0, pc);
      else        step(1'b0, OP_MUL, '0, '0, '0, 1'b0, pc);
      gp[i] = p_o[0];
    end
    checks++;
    if (gp[3] !== 48'd3) begin errors++; $display("FAIL casc_shift got %h want %h", gp[3], 48'd3); end
    for (int i = 1; i <= 5; i++) begin
      if (i == 1)      step(1'b1, OP_MUL, 27'h2_0000, 18'd1, '0, 1'b0, '0);
      else if (i == 2) step(1'b1, OP_MUL_ACC_SHIFT, '0, '0, '0, 1'b0, '0);
      else             step(1'b0, OP_MUL, '0, '0, '0, 1'b0, '0);
      gp[i] = p_o[0];
    end
    checks++;
    if (gp[3] !== 48'h2_0000 || gp[4] !== 48'd1) begin
      errors++;
      $display("FAIL acc_shift got %h,%h want %h,%h", gp[3], gp[4], 48'h2_0000, 48'd1);
    end
  endtask

  task automatic test_add_c();
    logic [PW-1:0] g0 [1:6];
    logic [PW-1:0] g1 [1:6];
    logic [PW-1:0] g2 [1:6];
    for (int i = 1; i <= 6; i++) begin
      if (i == 1)      step(1'b0, OP_MUL, '0, '0, 48'd100, 1'b1, '0);
      else if (i == 2) step(1'b1, OP_MUL_ADD_C, 27'd2, 18'd3, 48'd999, 1'b0, '0);
      else             step(1'b0, OP_MUL, '0, '0, 48'd999, 1'b0, '0);
      g0[i] = p_o[0]; g1[i] = p_o[1]; g2[i] = p_o[2];
    end
    checks++;
    if (g0[4] !== 48'd106) begin errors++; $display("FAIL add_c_creg got %0d want 106", g0[4]); end
    checks++;
    if (g1[2] !== 48'd1005) begin errors++; $display("FAIL add_c_nocreg got %0d want 1005", g1[2]); end
    checks++;
    if (g2[5] !== 48'd106) begin errors++; $display("FAIL add_c_lat4 got %0d want 106", g2[5]); end
  endtask

  task automatic test_bubble_hold();
    logic [PW-1:0] gp [1:8];
    logic          gv [1:8];
    logic [PW-1:0] ep [3:7] = '{48'd42, 48'd42, 48'd10, 48'd10, 48'd10};
    logic          ev [3:8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 1; i <= 8; i++) begin
      case (i)
        1: step(1'b1, OP_MUL, 27'd6, 18'd7, '0, 1'b0, '0);
        2: step(1'b0, OP_MUL, 27'd9, 18'd9, '0, 1'b0, '0);
        3: step(1'b1, OP_MUL, 27'd2, 18'd5, '0, 1'b0, '0);
        4: step(1'b1, OP_HOLD, 27'd9, 18'd9, '0, 1'b0, '0);
        5: step(1'b1, OP_RSVD, 27'd9, 18'd9, '0, 1'b0, '0);
        default: step(1'b0, OP_MUL, '0, '0, '0, 1'b0, '0);
      endcase
      gp[i] = p_o[0]; gv[i] = v_o[0];
    end
    for (int i = 3; i <= 8; i++) begin
      checks++;
      if (gv[i] !== ev[i]) begin
        errors++;
        $display("FAIL bubble_valid cycle%0d got %b want %b", i, gv[i], ev[i]);
      end
    end
    for (int i = 3; i <= 7; i++) begin
      checks++;
      if (gp[i] !== ep[i]) begin
        errors++;
        $display("FAIL bubble_hold_p cycle%0d got %0d want %0d", i, gp[i], ep[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, OP_MUL, 27'd3, 18'd3, '0, 1'b0, '0);
    step(1'b1, OP_MUL, 27'd4, 18'd4, '0, 1'b0, '0);
    step(1'b1, OP_MUL, 27'd5, 18'd5, '0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (p_o[k] !== '0 || v_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d got p=%h v=%b want 0", k, p_o[k], v_o[k]);
      end
    end
    #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, OP_MUL, '0, '0, '0, 1'b0, '0);
      checks++;
      if (v_o[0] !== 1'b0 || v_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL stale_valid cycle%0d got %b,%b want 0,0", i, v_o[0], v_o[2]);
      end
    end
    step(1'b1, OP_MUL, 27'd2, 18'd2, '0, 1'b0, '0);
    step(1'b0, OP_MUL, '0, '0, '0, 1'b0, '0);
    step(1'b0, OP_MUL, '0, '0, '0, 1'b0, '0);
    checks++;
    if (p_o[0] !== 48'd4 || v_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_op got p=%0d v=%b want p=4 v=1", p_o[0], v_o[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), AW'($urandom), BW'($urandom),
           PW'({$urandom, $urandom}), 1'($urandom), PW'({$urandom, $urandom}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_mul();
    test_mul_acc();
    test_shift();
    test_add_c();
    test_bubble_hold();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
